// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer and its score display:
// state/winner encodings, default match constants and a score helper.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE      = 3'd1,
        ST_PLAY       = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_GOAL_PAUSE = 3'd4,
        ST_GAME_OVER  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam int DEF_WIN_SCORE    = 5;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_PAUSE_FRAMES = 90;

    // Scores stop at the winning value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
        return (score >= limit) ? score : score + 4'd1;
    endfunction

endpackage

// File: rtl/pong_edge_det.sv
// Rising-edge detector for a vector of debounced level inputs; the pulse is
// combinational on the cycle the new level is first seen.
module pong_edge_det #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_lvl,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= i_lvl;
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_rise
        assign o_rise[gi] = i_lvl[gi] & ~prev_q[gi];
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, play, pause toggle, post-goal pause
// and game-over, driving the ball block's animate/reset and keeping scores.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ani_stb,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_goal_p1,
    input  logic       i_goal_p2,
    output logic       o_animate,
    output logic       o_ball_rst,
    output logic [3:0] o_score_p1,
    output logic [3:0] o_score_p2,
    output logic [1:0] o_winner,
    output logic [2:0] o_state
);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [3:0] WIN_Q      = 4'(WIN_SCORE);

    logic [3:0] rise;
    logic       start_r, pause_r, goal1_r, goal2_r;

    pong_edge_det #(.W(4)) u_edge (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_lvl  ({i_start, i_pause, i_goal_p1, i_goal_p2}),
        .o_rise (rise)
    );

    assign {start_r, pause_r, goal1_r, goal2_r} = rise;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    winner_t    winner_q, winner_d;
    logic       animate_q, ball_rst_q;
    logic [2:0] state_out_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (start_r) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (i_ani_stb) begin
                    if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_PLAY: begin
                // Goals take priority over a coincident pause request.
                if (goal1_r && goal2_r) begin
                    state_d = ST_GOAL_PAUSE;
                end else if (goal1_r) begin
                    score1_d = sat_inc(score1_q, WIN_Q);
                    if (score1_d == WIN_Q) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_P1;
                    end else begin
                        state_d = ST_GOAL_PAUSE;
                    end
                end else if (goal2_r) begin
                    score2_d = sat_inc(score2_q, WIN_Q);
                    if (score2_d == WIN_Q) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d = ST_GOAL_PAUSE;
                    end
                end else if (pause_r) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_r) state_d = ST_PLAY;
            end
            ST_GOAL_PAUSE: begin
                if (i_ani_stb) begin
                    if (cnt_q == PAUSE_LAST) state_d = ST_SERVE;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_GAME_OVER: begin
                if (start_r) begin
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WIN_NONE;
                    state_d  = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
        end
    end

    // Ball controls follow the state register one clock later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            animate_q   <= 1'b0;
            ball_rst_q  <= 1'b1;
            state_out_q <= ST_IDLE;
        end else begin
            animate_q   <= (state_q == ST_PLAY);
            ball_rst_q  <= !((state_q == ST_PLAY) || (state_q == ST_PAUSED));
            state_out_q <= state_q;
        end
    end

    assign o_animate  = animate_q;
    assign o_ball_rst = ball_rst_q;
    assign o_score_p1 = score1_q;
    assign o_score_p2 = score2_q;
    assign o_winner   = winner_q;
    assign o_state    = state_out_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: a table of level/strobe steps with
// expected outputs, plus hand sequences for held goals and async reset.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ani_stb, start, pause, goal1, goal2;
    logic       animate, ball_rst;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pong_match_ctrl dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ani_stb (ani_stb),
        .i_start   (start),
        .i_pause   (pause),
        .i_goal_p1 (goal1),
        .i_goal_p2 (goal2),
        .o_animate (animate),
        .o_ball_rst(ball_rst),
        .o_score_p1(score1),
        .o_score_p2(score2),
        .o_winner  (winner),
        .o_state   (state)
    );

    typedef struct {
        bit st, pa, g1, g2;
        int n_stb;
        int e_state, e_anim, e_brst, e_s1, e_s2, e_win;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, pa, g1, g2, input int n,
                       input int es, ea, eb, e1, e2, ew);
        vec_t v;
        v.st = st; v.pa = pa; v.g1 = g1; v.g2 = g2; v.n_stb = n;
        v.e_state = es; v.e_anim = ea; v.e_brst = eb;
        v.e_s1 = e1; v.e_s2 = e2; v.e_win = ew;
        tbl.push_back(v);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int n);
        repeat (n) begin
            ani_stb = 1'b1; tick();
            ani_stb = 1'b0; tick();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int es, ea, eb, e1, e2, ew);
        chk({tag, " state"},    int'(state),    es);
        chk({tag, " animate"},  int'(animate),  ea);
        chk({tag, " ball_rst"}, int'(ball_rst), eb);
        chk({tag, " score_p1"}, int'(score1),   e1);
        chk({tag, " score_p2"}, int'(score2),   e2);
        chk({tag, " winner"},   int'(winner),   ew);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    // From PLAY: score one goal; optionally run the goal pause and serve back to PLAY.
    task automatic point(input int who, input bit back_to_play);
        if (who == 1) goal1 = 1'b1; else goal2 = 1'b1;
        tick(3);
        goal1 = 1'b0; goal2 = 1'b0;
        tick(2);
        if (back_to_play) begin
            strobe(90);
            strobe(60);
            tick(2);
        end
    endtask

    initial begin
        rst_n = 1'b0; ani_stb = 1'b0; start = 1'b0;
        pause = 1'b0; goal1 = 1'b0; goal2 = 1'b0;

        //   st pa g1 g2   n   state an br s1 s2 win
        add(0, 0, 0, 0,  0,  0, 0, 1, 0, 0, 0);   // idle after reset
        add(1, 0, 0, 0,  0,  1, 0, 1, 0, 0, 0);   // start -> serve
        add(0, 0, 0, 0, 59,  1, 0, 1, 0, 0, 0);   // one strobe short
        add(0, 0, 0, 0,  1,  2, 1, 0, 0, 0, 0);   // 60th strobe -> play
        add(0, 0, 1, 0,  0,  4, 0, 1, 1, 0, 0);   // p1 goal
        add(0, 0, 1, 0, 89,  4, 0, 1, 1, 0, 0);   // held goal, one short
        add(0, 0, 1, 0,  1,  1, 0, 1, 1, 0, 0);   // 90th strobe -> serve
        add(0, 0, 0, 0, 60,  2, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0,  0,  3, 0, 0, 1, 0, 0);   // pause
        add(0, 0, 0, 1,  0,  3, 0, 0, 1, 0, 0);   // goal ignored while paused
        add(0, 1, 0, 1,  0,  2, 1, 0, 1, 0, 0);   // unpause, held goal no edge
        add(0, 0, 0, 0,  0,  2, 1, 0, 1, 0, 0);
        add(0, 0, 1, 1,  0,  4, 0, 1, 1, 0, 0);   // simultaneous goals
        add(0, 0, 0, 0, 90,  1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 60,  2, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0,  0,  2, 1, 0, 1, 0, 0);   // start ignored in play
        add(0, 1, 0, 1,  0,  4, 0, 1, 1, 1, 0);   // goal beats pause
        add(0, 0, 0, 0, 90,  1, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 60,  2, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1,  0,  4, 0, 1, 1, 2, 0);
        add(0, 0, 0, 0, 90,  1, 0, 1, 1, 2, 0);
        add(0, 0, 0, 0, 60,  2, 1, 0, 1, 2, 0);
        add(0, 0, 0, 1,  0,  4, 0, 1, 1, 3, 0);
        add(0, 0, 0, 0, 90,  1, 0, 1, 1, 3, 0);
        add(0, 0, 0, 0, 60,  2, 1, 0, 1, 3, 0);
        add(0, 0, 0, 1,  0,  4, 0, 1, 1, 4, 0);
        add(0, 0, 0, 0, 90,  1, 0, 1, 1, 4, 0);
        add(0, 0, 0, 0, 60,  2, 1, 0, 1, 4, 0);
        add(0, 0, 0, 1,  0,  5, 0, 1, 1, 5, 2);   // p2 wins
        add(0, 0, 0, 0,  0,  5, 0, 1, 1, 5, 2);
        add(0, 0, 1, 0,  0,  5, 0, 1, 1, 5, 2);   // goals ignored after win
        add(0, 0, 0, 1,  5,  5, 0, 1, 1, 5, 2);
        add(1, 0, 0, 0,  0,  1, 0, 1, 0, 0, 0);   // restart clears scores
        add(0, 0, 0, 0, 60,  2, 1, 0, 0, 0, 0);

        tick(2);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; pause = tbl[i].pa;
            goal1 = tbl[i].g1; goal2 = tbl[i].g2;
            tick(3);
            strobe(tbl[i].n_stb);
            tick(2);
            chk_all($sformatf("row%0d", i), tbl[i].e_state, tbl[i].e_anim,
                    tbl[i].e_brst, tbl[i].e_s1, tbl[i].e_s2, tbl[i].e_win);
            $display("row %0d: state=%0d anim=%0b brst=%0b score=%0d:%0d win=%0d",
                     i, state, animate, ball_rst, score1, score2, winner);
        end
        start = 1'b0; pause = 1'b0; goal1 = 1'b0; goal2 = 1'b0;

        // Goal level held for 500 cycles counts once.
        do_reset();
        start = 1'b1; tick(3); start = 1'b0; tick(2);
        strobe(60);
        tick(2);
        chk("seq play", int'(state), 2);
        goal1 = 1'b1;
        tick(500);
        chk_all("held500", 4, 0, 1, 1, 0, 0);
        strobe(90);
        tick(2);
        chk_all("held_serve", 1, 0, 1, 1, 0, 0);
        goal1 = 1'b0;
        tick(2);
        strobe(60);
        tick(2);
        $display("held goal: state=%0d score=%0d:%0d", state, score1, score2);

        // Build 3:2, leave it mid goal-pause, then reset between clock edges.
        point(1, 1'b1);
        point(1, 1'b1);
        point(2, 1'b1);
        point(2, 1'b0);
        strobe(10);
        chk_all("pre_rst", 4, 0, 1, 3, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 1, 0, 0, 0);
        $display("async reset: state=%0d brst=%0b score=%0d:%0d", state, ball_rst, score1, score2);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk_all("post_rst", 0, 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the Pong ball datapath. It decides when the ball animates, holds it reset between points, and counts goal events into scores. It runs serve countdowns, post-goal pauses, a player pause toggle and game-over detection. It sits between the top-level button/debounce logic and the ball block, driving the ball's animate and reset inputs and consuming its goal flags.

Parameters:
WIN_SCORE, 5, points needed to win a match (1..15)
SERVE_FRAMES, 60, animation strobes held in SERVE before play starts (1..255)
PAUSE_FRAMES, 90, animation strobes held in GOAL_PAUSE after a goal (1..255)

Ports:
i_clk  in  1  base clock
i_rst_n  in  1  asynchronous active-low reset
i_ani_stb  in  1  one-cycle animation strobe, once per frame
i_start  in  1  start/restart request, level, debounced
i_pause  in  1  pause toggle request, level, debounced
i_goal_p1  in  1  goal flag for player 1, level, may stay high for many cycles
i_goal_p2  in  1  goal flag for player 2, level
o_animate  out  1  ball animate enable
o_ball_rst  out  1  ball position reset, active-high
o_score_p1  out  4  player 1 score
o_score_p2  out  4  player 2 score
o_winner  out  2  00 none, 01 player 1, 10 player 2
o_state  out  3  encoded FSM state for display/debug

Behaviour:
- Async reset (i_rst_n low):
  - state=IDLE, scores=0, o_winner=00, frame counter=0, all edge-detect registers=0.
  - o_animate=0, o_ball_rst=1.
- Edge detection:
  - i_start, i_pause, i_goal_p1 and i_goal_p2 are each registered once.
  - Each acts on its rising edge only (cur & ~prev), on the i_clk cycle the edge is seen. No i_ani_stb qualification.
- States and encoding: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, GOAL_PAUSE=4, GAME_OVER=5. Encodings 6–7 are unreachable and recover to IDLE on the next clock.
- IDLE:
  - Start edge -> SERVE, frame counter=0.
- SERVE:
  - The counter increments on each i_ani_stb.
  - When counter==SERVE_FRAMES-1 and i_ani_stb is high -> PLAY, counter=0.
- PLAY:
  - Goal edges are evaluated first.
  - p1 edge alone: score_p1+1; p2 edge alone: score_p2+1.
  - Both edges in the same cycle: no score change, -> GOAL_PAUSE.
  - After a scoring update, if the new score == WIN_SCORE -> GAME_OVER and o_winner set; otherwise -> GOAL_PAUSE, counter=0.
  - A pause edge in a cycle with no goal edge -> PAUSED. If a goal edge and a pause edge coincide, the goal wins and the pause is dropped.
- PAUSED:
  - Pause edge -> PLAY.
  - Goal edges are ignored.
  - A start edge is also ignored.
- GOAL_PAUSE:
  - Counts i_ani_stb the same way as SERVE, terminating at PAUSE_FRAMES-1.
  - On expiry -> SERVE, counter=0.
  - Goal edges in this state are ignored, so a held level from the ball cannot double-count.
- GAME_OVER:
  - Scores and o_winner hold.
  - Start edge -> scores=0, o_winner=00, -> SERVE.
- Start edges in SERVE, PLAY and GOAL_PAUSE are ignored.
- Outputs are registered and change one clock after the state transition that causes them:
  - o_animate=1 only in PLAY.
  - o_ball_rst=1 in IDLE, SERVE, GOAL_PAUSE and GAME_OVER; 0 in PLAY and PAUSED.
  - o_state mirrors the state register.
- Width rules:
  - Scores are 4-bit and saturate at WIN_SCORE; they never wrap.
  - The frame counter is 8-bit and is cleared on every state entry.
- Reset mid-operation: any state returns to IDLE immediately. Scores are lost.

Decomposition:
- Shared package pong_pkg holds:
  - state encodings (ST_IDLE..ST_GAME_OVER)
  - winner encodings (WIN_NONE, WIN_P1, WIN_P2)
  - default WIN_SCORE, SERVE_FRAMES and PAUSE_FRAMES constants, also used by the score display.
- One natural sub-module: pong_edge_det, a parameterised-width rise detector with async active-low reset. It is instantiated once for the 4-bit {start, pause, goal_p1, goal_p2} vector.

Test Plan:
1. Reset, then start edge, then 60 strobes -> o_ball_rst=1 and o_animate=0 throughout SERVE; one clock after the 60th strobe, o_animate=1, o_ball_rst=0, o_state=2.
2. In PLAY, i_goal_p1 held high for 500 cycles -> o_score_p1 increments exactly once to 1; o_state=4; after 90 strobes, o_state=1.
3. Score p2 to 4, then one more p2 goal -> o_score_p2=5, o_winner=10, o_state=5, o_animate=0; further goal edges leave the scores unchanged.
4. i_goal_p1 and i_goal_p2 rise in the same cycle in PLAY -> both scores unchanged; o_state=4.
5. Pause edge in PLAY -> o_animate=0, o_state=3; a goal edge while PAUSED leaves the scores unchanged; a second pause edge -> o_animate=1, o_state=2.
6. i_rst_n pulsed low mid-GOAL_PAUSE with scores 3:2 -> immediately IDLE, scores 0:0, o_ball_rst=1; a start edge in GAME_OVER clears the scores and enters SERVE.
